mult_secuencial: RTL and testbench

MULT_SECUENCIAL -- requirements
Module: mult_secuencial

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_datapath.sv | 89 ++++++++
 rtl/mult_secuencial.sv | 119 +++++++++++
 tb/tb_mult_secuencial.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t       : controller states (IDLE, MULT, DONE)
//   DEFAULT_WIDTH : default operand width used by mult_secuencial and mult_datapath
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath of the sequential multiplier: operand magnitude capture,
// accumulator/multiplier shift register, adder and final sign correction.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : capture |a|, |b| and the result sign, clear the accumulator
//   step          : perform one add-and-shift iteration
//   finish        : with step, the current iteration is the last one; load producto
//   signed_mode   : operands are two's complement when 1
//   a, b          : multiplicand, multiplier
//   producto      : final product (held until the next finished multiplication)
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] producto
);

  localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    // Negating -2^(WIDTH-1) yields the same bit pattern, which read as an
    // unsigned magnitude is exactly 2^(WIDTH-1): no extra bit is needed.
    a_mag  = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag  = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;

    addend = mplier_q[0] ? mcand_q : '0;
    // Adder keeps its carry in sum[WIDTH]; the right shift of
    // {carry, acc, mplier} drops mplier[0] and brings the carry into acc.
    sum     = {1'b0, acc_q} + {1'b0, addend};
    shifted = {sum, mplier_q[WIDTH-1:1]};

    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    prod_d   = prod_q;

    if (load) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      acc_d    = '0;
      sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_d    = shifted[2*WIDTH-1:WIDTH];
      mplier_d = shifted[WIDTH-1:0];
      if (finish) begin
        prod_d = sign_q ? (~shifted + ONE_P) : shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      prod_q   <= prod_d;
    end
  end

  assign producto = prod_q;

endmodule

// File: rtl/mult_secuencial.sv
// Sequential WIDTH x WIDTH multiplier (signed or unsigned), one shift-add
// iteration per clock; the result appears WIDTH cycles after acceptance.
//   clk, rst            : clock, asynchronous active-low reset
//   valid / ready       : request handshake (ready only in IDLE)
//   signed_mode, a, b   : mode and operands, sampled at acceptance
//   producto            : 2*WIDTH result
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   flush               : synchronous abort back to IDLE
//   busy                : high while iterating (MULT)
//   contador            : current iteration index (debug)
//
// Handshake: a transfer happens on a rising edge where valid && ready (input
// side) or out_valid && out_ready (output side). Once out_valid is high,
// producto and out_valid stay unchanged until the transfer edge. ready, busy
// and out_valid are one-hot decodes of the controller state, so the state is
// always observable from the ports.
module mult_secuencial
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  output logic               ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] producto,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               busy,
  output logic [CW-1:0]      contador
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] contador_q, contador_d;
  logic          load, step, finish;

  always_comb begin
    state_d    = state_q;
    contador_d = contador_q;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;

    // flush overrides everything, including a request or the last iteration.
    if (flush) begin
      state_d    = IDLE;
      contador_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid) begin
            load       = 1'b1;
            contador_d = '0;
            state_d    = MULT;
          end
        end
        MULT: begin
          step = 1'b1;
          if (contador_q == LAST_IDX) begin
            finish     = 1'b1;
            contador_d = '0;
            state_d    = DONE;
          end else begin
            contador_d = contador_q + ONE_C;
          end
        end
        DONE: begin
          // ready is low here, so a request arriving together with the
          // output transfer waits for the following IDLE cycle.
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          contador_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      contador_q <= '0;
    end else begin
      state_q    <= state_d;
      contador_q <= contador_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == MULT);
  assign out_valid = (state_q == DONE);
  assign contador  = contador_q;

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .producto   (producto)
  );

endmodule

// File: tb/tb_mult_secuencial.sv
`timescale 1ns/1ps
module tb_mult_secuencial;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic           ready;
  logic           signed_mode;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] producto;
  logic           out_valid;
  logic           out_ready;
  logic           flush;
  logic           busy;
  logic [CW-1:0]  contador;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod = '0;

  typedef struct {
    logic           sm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t vecs[11];

  mult_secuencial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .ready      (ready),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .producto   (producto),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .busy       (busy),
    .contador   (contador)
  );

  // ---------------- clock / watchdog ----------------
  always #18.519 clk = ~clk;  // ~27 MHz

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer multiplication, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    if (sm) p = longint'($signed(x)) * longint'($signed(y));
    else    p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic [2*W-1:0] e);
    int guard = 0;
    while (!ready && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_req", ready, 1);
    signed_mode = sm;
    a           = aa;
    b           = bb;
    valid       = 1'b1;
    exp_q.push_back(e);
    tick();
    // Scramble inputs while the multiplication is in flight.
    valid       = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
    check("busy_after_accept", busy, 1);
    check("contador_at_accept", contador, 0);
  endtask

  // Waits for out_valid, checks latency/counter trace/result, holds the
  // result for 'hold' cycles of backpressure, then completes the transfer.
  task automatic wait_result(input int hold, input string name);
    int lat = 0;
    logic trace_ok = 1'b1;
    logic stable = 1'b1;
    logic [2*W-1:0] e;
    logic [2*W-1:0] snap;
    out_ready = (hold == 0);
    while (!out_valid && lat < 4 * W) begin
      if (contador != CW'(lat)) trace_ok = 1'b0;
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_contador_trace"}, trace_ok, 1);
    check({name, "_not_ready_in_done"}, {busy, ready}, 2'b00);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(name, producto, e);
      last_prod = e;
    end
    snap = producto;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || producto !== snap) stable = 1'b0;
    end
    if (hold > 0) check({name, "_held_stable"}, stable, 1);
    out_ready = 1'b1;
    tick();
    check({name, "_idle_after_accept"}, {ready, out_valid}, 2'b10);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic sm;
    logic [W-1:0] ra, rb;
    int guard;
    logic seen;

    vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'd143};
    vecs[1]  = '{1'b1, 8'hFD,  8'd5,   16'hFFF1};
    vecs[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[4]  = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[5]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[6]  = '{1'b0, 8'h80,  8'h02,  16'h0100};
    vecs[7]  = '{1'b1, 8'h80,  8'h01,  16'hFF80};
    vecs[8]  = '{1'b0, 8'h00,  8'h00,  16'h0000};
    vecs[9]  = '{1'b1, 8'h00,  8'h85,  16'h0000};
    vecs[10] = '{1'b0, 8'hFD,  8'd5,   16'h04F1};

    rst = 1'b0; valid = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_contador", contador, 0);
    check("reset_producto", producto, 0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      start_req(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_result(0, $sformatf("vec%0d", i));
    end

    // Backpressure: 7*9 held for 5 cycles
    start_req(1'b0, 8'd7, 8'd9, 16'd63);
    wait_result(5, "backpressure_7x9");

    // Request arriving in the same cycle as the output transfer
    start_req(1'b0, 8'd12, 8'd12, 16'd144);
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 4 * W) begin tick(); guard++; end
    check("done_12x12_valid", out_valid, 1);
    check("done_12x12", producto, exp_q.pop_front());
    out_ready = 1'b1; valid = 1'b1; signed_mode = 1'b0; a = 8'd5; b = 8'd5;
    tick();
    check("no_accept_in_done", {ready, busy}, 2'b10);
    exp_q.push_back(16'd25);
    tick();
    valid = 1'b0;
    check("accept_after_done", busy, 1);
    check("accept_after_done_cnt", contador, 0);
    wait_result(0, "req_after_done_5x5");

    // Asynchronous reset during MULT at contador==4
    start_req(1'b0, 8'd200, 8'd3, model(1'b0, 8'd200, 8'd3));
    guard = 0;
    while (contador != CW'(4) && guard < 20) begin tick(); guard++; end
    check("reach_contador_4", contador, 4);
    #5 rst = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_contador", contador, 0);
    check("midrst_producto", producto, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    start_req(1'b0, 8'd6, 8'd6, 16'd36);
    wait_result(0, "after_reset_6x6");

    // Flush during MULT at contador==3
    start_req(1'b1, 8'hF9, 8'd9, model(1'b1, 8'hF9, 8'd9));
    guard = 0;
    while (contador != CW'(3) && guard < 20) begin tick(); guard++; end
    check("reach_contador_3", contador, 3);
    flush = 1'b1; valid = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    check("flush_idle", {ready, busy}, 2'b10);
    check("flush_contador", contador, 0);
    check("flush_producto_kept", producto, last_prod);
    seen = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_out_valid", seen, 0);
    exp_q.delete();

    // Randomized against the reference model
    for (int i = 0; i < 24; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      start_req(sm, ra, rb, model(sm, ra, rb));
      wait_result($urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
